// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - two-requester round-robin arbiter in front of a shared fixed-latency ALU
// Responses are steered back through a LAT-deep tag pipe that mirrors the ALU latency.
module alu_req_arbiter #(
   parameter int WIDTH = 32,
   parameter int LAT   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_opcode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [4:0]       req0_shift,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_opcode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [4:0]       req1_shift,
   input  logic             hold,
   output logic             resp0_valid,
   output logic [WIDTH-1:0] resp0_result,
   output logic [2:0]       resp0_flags,
   output logic             resp0_err,
   output logic             resp1_valid,
   output logic [WIDTH-1:0] resp1_result,
   output logic [2:0]       resp1_flags,
   output logic             resp1_err,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_input1,
   output logic [WIDTH-1:0] alu_input2,
   output logic [4:0]       alu_shiftValue,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_zero,
   input  logic             alu_ovf,
   output logic [3:0]       inflight,
   output logic             idle
);

   typedef struct packed {
      logic v;
      logic id;
      logic err;
   } tag_t;

   tag_t       tag_q [LAT];
   tag_t       tag_in;
   tag_t       tag_out;
   logic       last_q, last_d;
   logic [3:0] inflight_q, inflight_d;
   logic       gnt0, gnt1, issue, rsp;
   logic [3:0] sel_opcode;

   // last_q holds the id of the most recent grant; the other side wins a tie
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst && !hold) begin
         if (req0_valid && req1_valid) begin
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
         end else if (req0_valid) begin
            gnt0 = 1'b1;
         end else if (req1_valid) begin
            gnt1 = 1'b1;
         end
      end
   end

   assign issue      = gnt0 | gnt1;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign sel_opcode = gnt1 ? req1_opcode : req0_opcode;

   always_comb begin
      alu_opcode     = '0;
      alu_input1     = '0;
      alu_input2     = '0;
      alu_shiftValue = '0;
      if (gnt0) begin
         alu_opcode     = req0_opcode;
         alu_input1     = req0_a;
         alu_input2     = req0_b;
         alu_shiftValue = req0_shift;
      end else if (gnt1) begin
         alu_opcode     = req1_opcode;
         alu_input1     = req1_a;
         alu_input2     = req1_b;
         alu_shiftValue = req1_shift;
      end
   end

   always_comb begin
      tag_in = '0;
      if (issue) begin
         tag_in.v   = 1'b1;
         tag_in.id  = gnt1;
         tag_in.err = (sel_opcode >= 4'd10);
      end
   end

   assign tag_out = tag_q[LAT-1];
   assign rsp     = tag_out.v && !rst;

   // Illegal opcodes return a clean zero regardless of what the ALU produced
   always_comb begin
      resp0_valid  = rsp && !tag_out.id;
      resp1_valid  = rsp &&  tag_out.id;
      resp0_err    = resp0_valid && tag_out.err;
      resp1_err    = resp1_valid && tag_out.err;
      resp0_result = '0;
      resp0_flags  = '0;
      resp1_result = '0;
      resp1_flags  = '0;
      if (resp0_valid && !tag_out.err) begin
         resp0_result = alu_result;
         resp0_flags  = {alu_ovf, alu_zero, alu_carry};
      end
      if (resp1_valid && !tag_out.err) begin
         resp1_result = alu_result;
         resp1_flags  = {alu_ovf, alu_zero, alu_carry};
      end
   end

   always_comb begin
      last_d     = issue ? gnt1 : last_q;
      inflight_d = inflight_q;
      case ({issue, rsp})
         2'b10:   inflight_d = inflight_q + 4'd1;
         2'b01:   inflight_d = inflight_q - 4'd1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
         inflight_q <= '0;
         last_q     <= 1'b1;
      end else begin
         tag_q[0] <= tag_in;
         for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
         inflight_q <= inflight_d;
         last_q     <= last_d;
      end
   end

   assign inflight = inflight_q;
   assign idle     = (inflight_q == 4'd0);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb/tb_alu_req_arbiter.sv - randomized bench with queue-based reference model and an emulated fixed-latency ALU
module tb_alu_req_arbiter;
   localparam int W   = 32;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst;
   logic req0_valid, req0_ready, req1_valid, req1_ready, hold;
   logic [3:0] req0_opcode, req1_opcode;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0] req0_shift, req1_shift;
   logic resp0_valid, resp0_err, resp1_valid, resp1_err;
   logic [W-1:0] resp0_result, resp1_result;
   logic [2:0] resp0_flags, resp1_flags;
   logic [3:0] alu_opcode;
   logic [W-1:0] alu_input1, alu_input2, alu_result;
   logic [4:0] alu_shiftValue;
   logic alu_carry, alu_zero, alu_ovf;
   logic [3:0] inflight;
   logic idle;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu_req_arbiter #(.WIDTH(W), .LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b), .req0_shift(req0_shift),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b), .req1_shift(req1_shift),
      .hold(hold),
      .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_flags(resp0_flags), .resp0_err(resp0_err),
      .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_flags(resp1_flags), .resp1_err(resp1_err),
      .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_shiftValue(alu_shiftValue),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
      .inflight(inflight), .idle(idle)
   );

   // Returns {ovf, zero, carry, result}; illegal opcodes give all-ones garbage so masking is visible
   function automatic logic [W+2:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [4:0] sh);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         c, o;
      c = 1'b0;
      o = 1'b0;
      r = '1;
      case (op)
         4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                     o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
         4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W];
                     o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << sh;
         4'd6: r = a >> sh;
         4'd7: r = $signed(a) >>> sh;
         4'd8: r = (a << sh) | (a >> (W - int'(sh)));
         4'd9: r = (a >> sh) | (a << (W - int'(sh)));
         default: begin r = '1; c = 1'b1; o = 1'b1; end
      endcase
      return {o, (r == '0), c, r};
   endfunction

   // Emulated external ALU: samples the issue bus mid-cycle, result appears LAT cycles later
   logic [W+2:0] alu_next;
   logic [W+2:0] alu_pipe [LAT];
   initial for (int i = 0; i < LAT; i++) alu_pipe[i] = '0;
   always @(negedge clk) alu_next = alu_f(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) alu_pipe[i] = alu_pipe[i-1];
      alu_pipe[0] = alu_next;
   end
   assign alu_result = alu_pipe[LAT-1][W-1:0];
   assign alu_carry  = alu_pipe[LAT-1][W];
   assign alu_zero   = alu_pipe[LAT-1][W+1];
   assign alu_ovf    = alu_pipe[LAT-1][W+2];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   // Reference model: outstanding operations as a queue ordered by due cycle
   typedef struct {
      int           due;
      bit           id;
      logic [W-1:0] res;
      logic [2:0]   fl;
      bit           err;
   } exp_t;
   exp_t q[$];
   bit   m_last  = 1'b1;
   bit   m_known = 1'b0;
   int   cyc = 0;

   always @(negedge clk) begin
      bit g0, g1, hit;
      logic [72:0] exp_bus;
      logic [36:0] e0, e1;
      logic [W+2:0] f;
      exp_t e;
      g0 = 1'b0; g1 = 1'b0;
      if (!rst && !hold) begin
         if (req0_valid && req1_valid) begin g0 = m_last; g1 = !m_last; end
         else begin g0 = req0_valid; g1 = req1_valid; end
      end
      chk("ready", {req0_ready, req1_ready}, {g0, g1});
      exp_bus = '0;
      if (g0) exp_bus = {req0_opcode, req0_a, req0_b, req0_shift};
      if (g1) exp_bus = {req1_opcode, req1_a, req1_b, req1_shift};
      chk("alu_bus", {alu_opcode, alu_input1, alu_input2, alu_shiftValue}, exp_bus);
      hit = 1'b0;
      if (!rst && q.size() > 0) hit = (q[0].due == cyc);
      e0 = '0; e1 = '0;
      if (hit) begin
         if (q[0].id) e1 = {1'b1, q[0].err, q[0].fl, q[0].res};
         else         e0 = {1'b1, q[0].err, q[0].fl, q[0].res};
      end
      chk("resp0", {resp0_valid, resp0_err, resp0_flags, resp0_result}, e0);
      chk("resp1", {resp1_valid, resp1_err, resp1_flags, resp1_result}, e1);
      if (m_known) begin
         chk("inflight", inflight, q.size());
         chk("idle", idle, q.size() == 0);
      end
      if (rst) begin
         q.delete();
         m_last  = 1'b1;
         m_known = 1'b1;
      end else begin
         if (hit) void'(q.pop_front());
         if (g0 || g1) begin
            e.due = cyc + LAT;
            e.id  = g1;
            if (g1) f = alu_f(req1_opcode, req1_a, req1_b, req1_shift);
            else    f = alu_f(req0_opcode, req0_a, req0_b, req0_shift);
            e.err = g1 ? (req1_opcode >= 10) : (req0_opcode >= 10);
            e.res = e.err ? '0 : f[W-1:0];
            e.fl  = e.err ? 3'b000 : f[W+2:W];
            q.push_back(e);
            m_last = g1;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      req0_valid = 0; req1_valid = 0; hold = 0;
   endtask

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return {1'b1, {(W-1){1'b0}}};
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1; hold = 0;
      req0_valid = 0; req0_opcode = 0; req0_a = 0; req0_b = 0; req0_shift = 0;
      req1_valid = 0; req1_opcode = 0; req1_a = 0; req1_b = 0; req1_shift = 0;
      #2;
      chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
      chk("rst_alu", {alu_opcode, alu_input1}, '0);
      tick(); tick();

      // Tie after reset: ADD 5+3 on req0, SUB 9-4 on req1
      rst = 0;
      req0_valid = 1; req0_opcode = 0; req0_a = 5; req0_b = 3;
      req1_valid = 1; req1_opcode = 1; req1_a = 9; req1_b = 4;
      #1 chk("tie_c0_ready", {req0_ready, req1_ready}, 2'b10);
      tick(); req0_valid = 0;
      #1 chk("tie_c1_ready", {req0_ready, req1_ready}, 2'b01);
      tick(); req1_valid = 0;
      #1 chk("tie_c2_resp0", {resp0_valid, resp0_result}, {1'b1, 32'd8});
      tick();
      #1 chk("tie_c3_resp1", {resp1_valid, resp1_result}, {1'b1, 32'd5});

      // Wrapping add sets zero and carry
      tick(); req0_valid = 1; req0_opcode = 0; req0_a = 32'hFFFF_FFFF; req0_b = 1;
      tick(); req0_valid = 0;
      tick();
      #1 chk("add_wrap", {resp0_valid, resp0_flags, resp0_result}, {1'b1, 3'b011, 32'd0});

      // Illegal opcode on req1
      tick(); req1_valid = 1; req1_opcode = 12; req1_a = 32'h1234; req1_b = 32'h55;
      tick(); req1_valid = 0;
      tick();
      #1 chk("illegal_resp1", {resp1_valid, resp1_err, resp1_flags, resp1_result}, {1'b1, 1'b1, 3'b000, 32'd0});
      chk("illegal_resp0", resp0_valid, 1'b0);

      // Six cycles of contention from a fresh reset, then hold
      tick(); rst = 1;
      tick(); rst = 0;
      req0_valid = 1; req0_opcode = 2; req0_a = 32'hF0F0; req0_b = 32'hFF00;
      req1_valid = 1; req1_opcode = 4; req1_a = 32'hAAAA; req1_b = 32'h5555;
      for (int i = 0; i < 6; i++) begin
         #1 chk("rr_ready", {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
         if (i >= 2) begin
            chk("rr_inflight", inflight, 4'd2);
            chk("rr_resp0", {resp0_valid, resp1_valid}, (i % 2 == 0) ? 2'b10 : 2'b01);
         end
         tick();
      end
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
         tick();
      end
      hold = 0;
      #1 chk("hold_release", {req0_ready, req1_ready}, 2'b10);
      tick(); quiet();

      // Operations in flight when reset hits are discarded
      repeat (3) tick();
      rst = 1;
      tick(); rst = 0; req0_valid = 1; req0_opcode = 3; req0_a = 7; req0_b = 8;
      tick();
      tick(); req0_valid = 0; rst = 1;
      #1 chk("flush_c2", {resp0_valid, resp1_valid}, 2'b00);
      tick(); rst = 0;
      for (int i = 3; i <= 5; i++) begin
         #1 chk("flush_resp", {resp0_valid, resp1_valid}, 2'b00);
         chk("flush_inflight", {inflight, idle}, {4'd0, 1'b1});
         tick();
      end

      // Randomized traffic
      repeat (500) begin
         rst  = ($urandom_range(0, 59) == 0);
         hold = ($urandom_range(0, 9) == 0);
         req0_valid = ($urandom_range(0, 9) < 7);
         req1_valid = ($urandom_range(0, 9) < 7);
         req0_opcode = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         req1_opcode = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         req0_a = rnd_operand(); req0_b = rnd_operand(); req0_shift = 5'($urandom);
         req1_a = rnd_operand(); req1_b = rnd_operand(); req1_shift = 5'($urandom);
         tick();
      end
      rst = 0; quiet();
      repeat (LAT + 3) tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width.
REQ-002 Parameter LAT, default 2: fixed ALU issue-to-result latency in cycles, legal range 1-8.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 reqN_valid (N=0,1)  in  1  requester N has an operation pending.
REQ-006 reqN_ready  out  1  requester N granted this cycle; issue occurs when valid and ready are both 1.
REQ-007 reqN_opcode  in  4  ALU opcode; values 0-9 legal, 10-15 illegal.
REQ-008 reqN_a, reqN_b  in  WIDTH  operands.
REQ-009 reqN_shift  in  5  shift/rotate amount.
REQ-010 hold  in  1  when 1, blocks new grants; in-flight operations still complete.
REQ-011 respN_valid  out  1  one-cycle pulse: result for requester N.
REQ-012 respN_result  out  WIDTH  result; respN_flags  out  3  {overflow, zero, carry}; respN_err  out  1  illegal opcode.
REQ-013 alu_opcode  out  4; alu_input1, alu_input2  out  WIDTH; alu_shiftValue  out  5: drive the shared ALU.
REQ-014 alu_result  in  WIDTH; alu_carry, alu_zero, alu_ovf  in  1: ALU outputs, valid LAT cycles after issue.
REQ-015 inflight  out  4  count of issued operations without a response yet; idle  out  1  equals (inflight==0).

Function
REQ-016 At most one issue per cycle; at most one reqN_ready is 1 in any cycle.
REQ-017 Both reqN_ready are 0 when hold=1 or rst=1.
REQ-018 Exactly one requester valid: that requester is granted in the same cycle (combinational ready).
REQ-019 Both requesters valid: grant the requester not granted most recently (round-robin).
REQ-020 Last-grant pointer updates only in cycles where an issue occurs.
REQ-021 Issue cycle: alu_* outputs carry the granted requester's opcode, operands and shift.
REQ-022 No-issue cycle: alu_opcode=0 and alu_input1, alu_input2, alu_shiftValue=0.
REQ-023 Each issue pushes a tag {valid=1, id, err} into a LAT-deep shift register.
REQ-024 err is 1 when the opcode is in 10-15.
REQ-025 No-issue cycle pushes valid=0 into the tag shift register.
REQ-026 Operation issued in cycle k produces respN_valid=1 for its requester in cycle k+LAT, nothing for the other requester.
REQ-027 Response cycle: respN_result=alu_result and respN_flags={alu_ovf, alu_zero, alu_carry}.
REQ-028 Response with err=1: respN_result=0 and respN_flags=0 regardless of ALU outputs.
REQ-029 Non-response cycle: respN_valid=0 and respN_result, respN_flags, respN_err=0.
REQ-030 Responses cannot be back-pressured; requesters accept every pulse.
REQ-031 Back-to-back issues every cycle are legal; responses return in issue order, one per cycle.
REQ-032 inflight +1 on issue, -1 on response, unchanged when both occur in the same cycle; never exceeds LAT.
REQ-033 A requester deasserting valid without a grant loses nothing; no request is latched internally.

Reset
REQ-034 rst=1 at a posedge clears every tag valid bit, sets inflight=0 and sets the pointer so req0 wins the first tie.
REQ-035 Cycle after reset: all respN_valid=0, idle=1.
REQ-036 Operations in flight when rst asserts produce no response, then or after reset.
REQ-037 Outputs during an rst=1 cycle: ready=0, alu_* outputs=0, resp outputs=0.

Verification
REQ-038 Tie after reset: req0/req1 valid in cycle 0 with ADD 5+3 / SUB 9-4 (LAT=2).
  -> cycle 0: req0_ready=1; cycle 1: req1_ready=1; cycle 2: resp0 result 8; cycle 3: resp1 result 5.
REQ-039 Both valid for 6 cycles -> grants alternate 0,1,0,1,0,1; inflight stays at 2 from cycle 2; responses alternate the same way.
REQ-040 req1 issues opcode 12 -> resp1 at +LAT with err=1, result=0, flags=0; ALU outputs ignored.
REQ-041 hold=1 while both valid -> no ready for the hold duration.
  -> Issue resumes the cycle hold falls, winner per round-robin pointer.
REQ-042 Issue in cycles 0 and 1, rst=1 in cycle 2 -> no respN_valid in cycles 2-5; inflight=0; idle=1.
REQ-043 ADD 0xFFFFFFFF+1 from req0 -> resp0 result 0, flags=3'b011 (zero, carry).
